aes256_job_ctrl: RTL and testbench

Sequencer and arbiter placed in front of the single AES-256 core inside aes256_impl. It accepts encrypt/decrypt jobs from two requesters: port 0 for the host/UART path and port 1 for the built-in known-answer self-test. It grants the requesters round-robin and caches the expanded key, so key expansion runs only when the key changes. It drives the core's init/next handshake, guards each core wait with a watchdog, and returns one response per job.

---
 rtl/aes256_job_ctrl_if.sv | 57 +++++
 rtl/aes256_job_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_aes256_job_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes256_job_ctrl_if.sv
`timescale 1ns/1ps
// aes256_job_ctrl_if: bundles the two job ports, the response port and the AES core handshake.
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs on each job port and the response port.
interface aes256_job_ctrl_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [255:0] req0_key;
  logic [127:0] req0_block;
  logic         req0_dec;

  logic         req1_valid;
  logic         req1_ready;
  logic [255:0] req1_key;
  logic [127:0] req1_block;
  logic         req1_dec;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [127:0] rsp_data;
  logic         rsp_err;

  logic [255:0] core_key;
  logic [127:0] core_block;
  logic         core_encdec;
  logic         core_init;
  logic         core_next;
  logic         core_key_ready;
  logic         core_ready;
  logic [127:0] core_result;

  logic         busy;
  logic [7:0]   err_count;

  // Requesters, response consumer and core side
  modport master (
    output req0_valid, req0_key, req0_block, req0_dec,
    output req1_valid, req1_key, req1_block, req1_dec,
    output rsp_ready, core_key_ready, core_ready, core_result,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    input  core_key, core_block, core_encdec, core_init, core_next,
    input  busy, err_count
  );

  // Job controller side
  modport slave (
    input  req0_valid, req0_key, req0_block, req0_dec,
    input  req1_valid, req1_key, req1_block, req1_dec,
    input  rsp_ready, core_key_ready, core_ready, core_result,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    output core_key, core_block, core_encdec, core_init, core_next,
    output busy, err_count
  );
endinterface

// File: rtl/aes256_job_ctrl.sv
`timescale 1ns/1ps
// aes256_job_ctrl: two-port round-robin job sequencer for one AES-256 core, with expanded-key cache and watchdog.
// Latency: key hit -> rsp_valid rises on the 3rd clock edge after the accept edge; key miss adds init, guard and key wait.
// Backpressure: one job in flight; both request readys stay low until the response is taken with rsp_ready.
module aes256_job_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input logic              clk10,
  input logic              reset,
  aes256_job_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_INIT  = 3'd1,
    KEY_WAIT  = 3'd2,
    BLK_START = 3'd3,
    BLK_WAIT  = 3'd4,
    RESP      = 3'd5
  } state_t;

  // Watchdog value seen on the last permitted wait cycle
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t       state;
  logic         last_grant;
  logic         key_valid;
  logic [255:0] cached_key;
  logic [255:0] key_q;
  logic [127:0] block_q;
  logic         id_q;
  logic [TO_W-1:0] wd;

  logic         core_init_q;
  logic         core_next_q;
  logic         core_encdec_q;
  logic         rsp_valid_q;
  logic         rsp_id_q;
  logic [127:0] rsp_data_q;
  logic         rsp_err_q;
  logic         busy_q;
  logic [7:0]   err_count_q;

  logic         grant0;
  logic         grant1;
  logic [255:0] acc_key;
  logic [127:0] acc_block;
  logic         acc_dec;
  logic         wait_done;

  // Round-robin pick in IDLE; reset masks the readys so every output is low while it is held
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Payload of the granted requester and the done flag of whichever core wait is active
  always_comb begin
    acc_key   = grant1 ? bus.req1_key   : bus.req0_key;
    acc_block = grant1 ? bus.req1_block : bus.req0_block;
    acc_dec   = grant1 ? bus.req1_dec   : bus.req0_dec;
    wait_done = (state == KEY_WAIT) ? bus.core_key_ready : bus.core_ready;
  end

  // Job sequencer: accept, optional key expansion, block run, response hold
  always_ff @(posedge clk10 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      key_valid     <= 1'b0;
      cached_key    <= '0;
      key_q         <= '0;
      block_q       <= '0;
      id_q          <= 1'b0;
      wd            <= '0;
      core_init_q   <= 1'b0;
      core_next_q   <= 1'b0;
      core_encdec_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      err_count_q   <= '0;
    end else begin
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            key_q         <= acc_key;
            block_q       <= acc_block;
            core_encdec_q <= !acc_dec;
            id_q          <= grant1;
            last_grant    <= grant1;
            busy_q        <= 1'b1;
            if (key_valid && cached_key == acc_key) begin
              state       <= BLK_START;
              core_next_q <= 1'b1;
            end else begin
              state       <= KEY_INIT;
              core_init_q <= 1'b1;
            end
          end
        end
        KEY_INIT: begin
          cached_key <= key_q;
          key_valid  <= 1'b0;
          wd         <= '0;
          state      <= KEY_WAIT;
        end
        BLK_START: begin
          wd    <= '0;
          state <= BLK_WAIT;
        end
        KEY_WAIT, BLK_WAIT: begin
          // wd==0 marks the guard cycle: the core may still show the previous ready
          if (wd != '0 && wait_done) begin
            if (state == KEY_WAIT) begin
              key_valid   <= 1'b1;
              core_next_q <= 1'b1;
              state       <= BLK_START;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_id_q    <= id_q;
              rsp_data_q  <= bus.core_result;
              rsp_err_q   <= 1'b0;
              state       <= RESP;
            end
          end else if (wd == WD_LAST) begin
            // Abort: the core state is unknown, so force a fresh key expansion next time
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            key_valid   <= 1'b0;
            state       <= RESP;
            if (err_count_q != 8'hFF) begin
              err_count_q <= err_count_q + 8'd1;
            end
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.core_key    = key_q;
  assign bus.core_block  = block_q;
  assign bus.core_encdec = core_encdec_q;
  assign bus.core_init   = core_init_q;
  assign bus.core_next   = core_next_q;
  assign bus.busy        = busy_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_aes256_job_ctrl.sv
`timescale 1ns/1ps
// tb_aes256_job_ctrl: directed jobs through both ports against a table-driven core model.
// Latency: measured in negedges from the negedge following the accept edge.
// Backpressure: rsp_ready is held low in one step to check that the response holds.
module tb_aes256_job_ctrl;

  localparam logic [255:0] K_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT     = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K2     = 256'hdeadbeef_00000001_cafef00d_00000002_0badc0de_00000003_feedface_00000004;
  localparam logic [127:0] B2     = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  typedef struct packed {
    logic         id;
    logic [127:0] data;
    logic         err;
  } rsp_t;

  logic clk10;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   init_cnt = 0;
  int   next_cnt = 0;
  int   overlap  = 0;
  rsp_t sb[$];

  aes256_job_ctrl_if bus ();

  aes256_job_ctrl #(.TIMEOUT_CYCLES(1024), .TO_W(11)) dut (
    .clk10 (clk10),
    .reset (reset),
    .bus   (bus)
  );

  initial clk10 = 1'b0;
  always #50 clk10 = ~clk10;

  // Core model: the FIPS-197 C.3 pair, anything else a keyed scramble
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] b, input logic enc);
    if (k == K_FIPS && enc && b == PT) return CT;
    if (k == K_FIPS && !enc && b == CT) return PT;
    return b ^ k[127:0] ^ k[255:128] ^ {127'd0, enc};
  endfunction

  assign bus.core_result = core_fn(bus.core_key, bus.core_block, bus.core_encdec);

  // Pulse and ready-overlap monitor
  always @(negedge clk10) begin
    if (bus.core_init) init_cnt++;
    if (bus.core_next) next_cnt++;
    if (bus.req0_ready && bus.req1_ready) overlap++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a handshake on either port; returns at the negedge after the accept edge
  task automatic wait_grant(input string tag, output int g);
    int n = 0;
    logic hs0, hs1;
    #1;
    hs0 = bus.req0_valid && bus.req0_ready;
    hs1 = bus.req1_valid && bus.req1_ready;
    while (!(hs0 || hs1) && n < 4000) begin
      @(negedge clk10);
      n++;
      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;
    end
    check({tag, "_accept"}, hs0 || hs1, 1);
    g = hs1 ? 1 : 0;
    @(negedge clk10);
  endtask

  // Waits for rsp_valid, compares with the scoreboard head, consumes it
  task automatic expect_rsp(input string tag, output int lat);
    rsp_t e;
    int n = 0;
    while (!bus.rsp_valid && n < 3000) begin
      @(negedge clk10);
      n++;
    end
    lat = n;
    check({tag, "_valid"}, bus.rsp_valid, 1);
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, "_id"}, bus.rsp_id, e.id);
    check({tag, "_data"}, bus.rsp_data, e.data);
    check({tag, "_err"}, bus.rsp_err, e.err);
    bus.rsp_ready = 1'b1;
    @(negedge clk10);
  endtask

  task automatic set_req0(input logic [255:0] k, input logic [127:0] b, input logic d);
    bus.req0_key = k; bus.req0_block = b; bus.req0_dec = d; bus.req0_valid = 1'b1;
  endtask

  task automatic set_req1(input logic [255:0] k, input logic [127:0] b, input logic d);
    bus.req1_key = k; bus.req1_block = b; bus.req1_dec = d; bus.req1_valid = 1'b1;
  endtask

  initial begin
    int   lat;
    int   g;
    int   acc0;
    int   acc1;
    int   bad;
    rsp_t e;

    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_key = '0; bus.req0_block = '0; bus.req0_dec = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_key = '0; bus.req1_block = '0; bus.req1_dec = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.core_key_ready = 1'b1;
    bus.core_ready = 1'b1;
    repeat (3) @(negedge clk10);

    // Reset state
    check("rst_ctrl", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                       bus.busy, bus.core_init, bus.core_next, bus.core_encdec, bus.err_count}, '0);
    check("rst_key", bus.core_key, '0);
    check("rst_data_block", {bus.rsp_data, bus.core_block}, '0);
    reset = 1'b0;
    @(negedge clk10);

    // Single encrypt job, cold key: init then next, 6 negedges to response
    init_cnt = 0; next_cnt = 0;
    sb.push_back('{id: 1'b0, data: CT, err: 1'b0});
    set_req0(K_FIPS, PT, 1'b0);
    wait_grant("job1", g);
    bus.req0_valid = 1'b0;
    check("job1_port", g, 0);
    check("job1_busy", bus.busy, 1);
    expect_rsp("job1", lat);
    check("job1_lat", lat, 6);
    check("job1_init_pulses", init_cnt, 1);
    check("job1_next_pulses", next_cnt, 1);
    check("job1_encdec", bus.core_encdec, 1);
    check("job1_core_key", bus.core_key, K_FIPS);

    // Key cache hit, decrypt: no init; rsp_valid rises on the 3rd edge after accept
    init_cnt = 0; next_cnt = 0;
    sb.push_back('{id: 1'b0, data: PT, err: 1'b0});
    set_req0(K_FIPS, CT, 1'b1);
    wait_grant("job2", g);
    bus.req0_valid = 1'b0;
    expect_rsp("job2", lat);
    check("job2_lat", lat, 3);
    check("job2_init_pulses", init_cnt, 0);
    check("job2_next_pulses", next_cnt, 1);
    check("job2_encdec", bus.core_encdec, 0);
    check("job2_rsp_drop", bus.rsp_valid, 0);

    // Watchdog: core never finishes; abort 1024 cycles after BLK_WAIT entry
    bus.core_ready = 1'b0;
    sb.push_back('{id: 1'b0, data: 128'd0, err: 1'b1});
    set_req0(K_FIPS, PT, 1'b0);
    wait_grant("wd", g);
    bus.req0_valid = 1'b0;
    expect_rsp("wd", lat);
    check("wd_lat", lat, 1025);
    check("wd_err_count", bus.err_count, 1);
    bus.core_ready = 1'b1;

    // After an abort the same key must be expanded again
    init_cnt = 0;
    sb.push_back('{id: 1'b0, data: CT, err: 1'b0});
    set_req0(K_FIPS, PT, 1'b0);
    wait_grant("wd_rekey", g);
    bus.req0_valid = 1'b0;
    expect_rsp("wd_rekey", lat);
    check("wd_rekey_init", init_cnt, 1);

    // Done on the final watchdog cycle wins over the timeout
    bus.core_ready = 1'b0;
    sb.push_back('{id: 1'b0, data: CT, err: 1'b0});
    set_req0(K_FIPS, PT, 1'b0);
    wait_grant("tie", g);
    bus.req0_valid = 1'b0;
    repeat (1024) @(negedge clk10);
    check("tie_not_early", bus.rsp_valid, 0);
    bus.core_ready = 1'b1;
    expect_rsp("tie", lat);
    check("tie_lat", lat, 1);
    check("tie_err_count", bus.err_count, 1);

    // Backpressure: response held 20 cycles while requester 0 waits
    bus.rsp_ready = 1'b0;
    sb.push_back('{id: 1'b1, data: core_fn(K2, B2, 1'b1), err: 1'b0});
    set_req1(K2, B2, 1'b0);
    wait_grant("bp", g);
    bus.req1_valid = 1'b0;
    check("bp_port", g, 1);
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clk10);
      lat++;
    end
    sb.push_back('{id: 1'b0, data: CT, err: 1'b0});
    set_req0(K_FIPS, PT, 1'b0);
    e = sb[0];
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk10);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_data !== e.data ||
          bus.rsp_err !== e.err || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
          bus.busy !== 1'b1) bad++;
    end
    check("bp_hold_stable", bad, 0);
    bus.rsp_ready = 1'b1;
    expect_rsp("bp", lat);
    check("bp_rsp_drop", bus.rsp_valid, 0);
    check("bp_idle_busy", bus.busy, 0);
    wait_grant("bp_next", g);
    bus.req0_valid = 1'b0;
    check("bp_next_port", g, 0);
    expect_rsp("bp_next", lat);

    // Contention from reset: grants 0,1,0,1
    @(negedge clk10);
    reset = 1'b1;
    set_req0(K_FIPS, PT, 1'b0);
    set_req1(K2, B2, 1'b0);
    sb.push_back('{id: 1'b0, data: CT, err: 1'b0});
    sb.push_back('{id: 1'b1, data: core_fn(K2, B2, 1'b1), err: 1'b0});
    sb.push_back('{id: 1'b0, data: CT, err: 1'b0});
    sb.push_back('{id: 1'b1, data: core_fn(K2, B2, 1'b1), err: 1'b0});
    repeat (2) @(negedge clk10);
    check("cont_rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    reset = 1'b0;
    acc0 = 0;
    acc1 = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant($sformatf("cont%0d", i), g);
      check($sformatf("cont_grant%0d", i), g, i % 2);
      if (g == 0) acc0++; else acc1++;
      if (acc0 == 2) bus.req0_valid = 1'b0;
      if (acc1 == 2) bus.req1_valid = 1'b0;
      expect_rsp($sformatf("cont_rsp%0d", i), lat);
    end

    // Reset in KEY_WAIT abandons the job; the same job then re-expands the key
    bus.core_key_ready = 1'b0;
    set_req0(K_FIPS, PT, 1'b0);
    wait_grant("mid", g);
    bus.req0_valid = 1'b0;
    repeat (3) @(negedge clk10);
    check("mid_busy_before", bus.busy, 1);
    #10 reset = 1'b1;
    #1;
    check("mid_rst_ctrl", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                           bus.busy, bus.core_init, bus.core_next, bus.core_encdec, bus.err_count}, '0);
    check("mid_rst_key", bus.core_key, '0);
    check("mid_rst_data_block", {bus.rsp_data, bus.core_block}, '0);
    repeat (2) @(negedge clk10);
    reset = 1'b0;
    bus.core_key_ready = 1'b1;
    @(negedge clk10);
    init_cnt = 0;
    sb.push_back('{id: 1'b0, data: CT, err: 1'b0});
    set_req0(K_FIPS, PT, 1'b0);
    wait_grant("mid_re", g);
    bus.req0_valid = 1'b0;
    expect_rsp("mid_re", lat);
    check("mid_re_init", init_cnt, 1);

    check("ready_overlap", overlap, 0);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
